lsu_ld_ctrl: RTL

LSU load controller that sits directly upstream of the AXI read interface block.
- Accepts one strided load command from the instruction decoder.
- Issues one AXI read burst per row through the lsu_axi_* request port.
- Consumes the returned beats and writes each 64-bit beat into the local operand buffer.
- Reports completion and any error to the decoder.

---
 rtl/lsu_pkg.sv | 42 ++++
 rtl/lsu_ld_addr_gen.sv | 55 +++++
 rtl/lsu_ld_ctrl.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// LSU shared definitions: AXI read constants, stride decode
// and the load-controller state encoding.
package lsu_pkg;

    localparam logic [2:0] SIZE_8B    = 3'b011;
    localparam logic [1:0] BURST_INCR = 2'b01;

    localparam logic [2:0] STR_16  = 3'd0;
    localparam logic [2:0] STR_32  = 3'd1;
    localparam logic [2:0] STR_64  = 3'd2;
    localparam logic [2:0] STR_128 = 3'd3;
    localparam logic [2:0] STR_256 = 3'd4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } ld_state_e;

    // Reserved codes fall back to the 16-byte stride.
    function automatic logic [8:0] stride_bytes(
        input logic [2:0] code
    );
        logic [8:0] s;
        s = 9'd16;
        case (code)
            STR_32:  s = 9'd32;
            STR_64:  s = 9'd64;
            STR_128: s = 9'd128;
            STR_256: s = 9'd256;
            default: s = 9'd16;
        endcase
        return s;
    endfunction

    function automatic logic stride_bad(
        input logic [2:0] code
    );
        return code > STR_256;
    endfunction

endpackage

// File: rtl/lsu_ld_addr_gen.sv
// Row request generator: issued-row count, strided row address
// and the rows-in-flight limit on the AR channel.
module lsu_ld_addr_gen
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int OUTST  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [8:0]        stride,
    input  logic [3:0]        rows,
    input  logic              run,
    input  logic              row_done,
    input  logic              ar_rdy,
    output logic              ar_vld,
    output logic [ADDR_W-1:0] ar_addr,
    output logic [7:0]        ar_id
);

    logic [3:0] issued;
    logic [3:0] inflight;
    logic       ar_fire;

    assign ar_vld  = run && (issued < rows)
                  && (inflight < 4'(OUTST));
    assign ar_fire = ar_vld && ar_rdy;
    assign ar_id   = {4'b0, issued};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            issued   <= '0;
            inflight <= '0;
            ar_addr  <= '0;
        end else if (start) begin
            issued   <= '0;
            inflight <= '0;
            ar_addr  <= start_addr;
        end else begin
            if (ar_fire) begin
                issued  <= issued + 4'd1;
                ar_addr <= ar_addr + ADDR_W'(stride);
            end
            // Simultaneous issue and retire cancel out.
            case ({ar_fire, row_done})
                2'b10:   inflight <= inflight + 4'd1;
                2'b01:   inflight <= inflight - 4'd1;
                default: inflight <= inflight;
            endcase
        end
    end

endmodule

// File: rtl/lsu_ld_ctrl.sv
// Strided load controller: one AXI read burst per row, each
// returned beat written into the local operand buffer.
module lsu_ld_ctrl
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 64,
    parameter int BUF_AW = 6,
    parameter int OUTST  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_vld,
    output logic              cmd_rdy,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [3:0]        cmd_rows,
    input  logic [7:0]        cmd_len,
    input  logic [2:0]        cmd_str,
    input  logic [BUF_AW-1:0] cmd_buf_base,
    output logic [7:0]        lsu_axi_arid,
    output logic [ADDR_W-1:0] lsu_axi_araddr,
    output logic [7:0]        lsu_axi_arlen,
    output logic [2:0]        lsu_axi_arsize,
    output logic [1:0]        lsu_axi_arburst,
    output logic [2:0]        lsu_axi_arstr,
    output logic              lsu_axi_arvld,
    input  logic              axi_lsu_arrdy,
    input  logic [7:0]        axi_lsu_rid,
    input  logic [DATA_W-1:0] axi_lsu_rdata,
    input  logic [1:0]        axi_lsu_rresp,
    input  logic              axi_lsu_rlast,
    input  logic              axi_lsu_rvld,
    output logic              lsu_axi_rrdy,
    output logic              buf_wen,
    output logic [BUF_AW-1:0] buf_waddr,
    output logic [DATA_W-1:0] buf_wdata,
    output logic              busy,
    output logic              ld_done,
    output logic              ld_err
);

    ld_state_e         state_q, state_d;
    logic [3:0]        rows_q;
    logic [7:0]        len_q;
    logic [2:0]        str_q;
    logic [8:0]        stride_q;
    logic [3:0]        rx_row;
    logic [7:0]        beat_cnt;
    logic [BUF_AW-1:0] wptr;

    logic cmd_acc;
    logic beat_run;
    logic row_end;
    logic last_row;
    logic beat_err;

    assign lsu_axi_rrdy    = 1'b1;
    assign lsu_axi_arsize  = SIZE_8B;
    assign lsu_axi_arburst = BURST_INCR;
    assign lsu_axi_arlen   = len_q;
    assign lsu_axi_arstr   = str_q;

    assign cmd_acc  = cmd_vld && cmd_rdy;
    // Beats outside RUN are stale and simply drained.
    assign beat_run = axi_lsu_rvld && lsu_axi_rrdy
                   && (state_q == RUN);
    assign row_end  = beat_run && (beat_cnt == len_q);
    assign last_row = (rx_row == rows_q - 4'd1);

    assign beat_err = (axi_lsu_rresp != 2'b00)
        || (axi_lsu_rlast && (beat_cnt < len_q))
        || (!axi_lsu_rlast && (beat_cnt == len_q))
        || (axi_lsu_rid != {4'b0, rx_row});

    lsu_ld_addr_gen #(
        .ADDR_W (ADDR_W),
        .OUTST  (OUTST)
    ) u_addr_gen (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (cmd_acc),
        .start_addr (cmd_addr),
        .stride     (stride_q),
        .rows       (rows_q),
        .run        (state_q == RUN),
        .row_done   (row_end),
        .ar_rdy     (axi_lsu_arrdy),
        .ar_vld     (lsu_axi_arvld),
        .ar_addr    (lsu_axi_araddr),
        .ar_id      (lsu_axi_arid)
    );

    always_comb begin
        state_d = state_q;
        cmd_rdy = 1'b0;
        busy    = 1'b0;
        ld_done = 1'b0;
        unique case (state_q)
            IDLE: begin
                cmd_rdy = 1'b1;
                if (cmd_vld)
                    state_d = (cmd_rows == 4'd0) ? DONE : RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (row_end && last_row)
                    state_d = DONE;
            end
            DONE: begin
                busy    = 1'b1;
                ld_done = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            rows_q    <= '0;
            len_q     <= '0;
            str_q     <= '0;
            stride_q  <= '0;
            rx_row    <= '0;
            beat_cnt  <= '0;
            wptr      <= '0;
            ld_err    <= 1'b0;
            buf_wen   <= 1'b0;
            buf_waddr <= '0;
            buf_wdata <= '0;
        end else begin
            state_q <= state_d;
            buf_wen <= beat_run;
            if (beat_run) begin
                buf_waddr <= wptr;
                buf_wdata <= axi_lsu_rdata;
            end
            if (cmd_acc) begin
                rows_q   <= cmd_rows;
                len_q    <= cmd_len;
                str_q    <= cmd_str;
                stride_q <= stride_bytes(cmd_str);
                ld_err   <= stride_bad(cmd_str);
                rx_row   <= '0;
                beat_cnt <= '0;
                wptr     <= cmd_buf_base;
            end else if (beat_run) begin
                wptr <= wptr + 1'b1;
                if (beat_err)
                    ld_err <= 1'b1;
                // Row length, not rlast, decides completion.
                if (row_end) begin
                    beat_cnt <= '0;
                    rx_row   <= rx_row + 4'd1;
                end else begin
                    beat_cnt <= beat_cnt + 8'd1;
                end
            end
        end
    end

endmodule
